// File: rtl/sap_controller_sequencer.sv
// Control sequencer for the 8-bit SAP datapath: a one-hot T1..T6 ring counter
// plus a combinational control-word decode of the ring state and the current opcode.
module sap_controller_sequencer #(
   parameter logic [3:0] OP_LDA = 4'b0000,
   parameter logic [3:0] OP_ADD = 4'b0001,
   parameter logic [3:0] OP_SUB = 4'b0010,
   parameter logic [3:0] OP_OUT = 4'b1110,
   parameter logic [3:0] OP_HLT = 4'b1111
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] opcode,
   output logic       cp,
   output logic       ep,
   output logic       lm_n,
   output logic       ce_n,
   output logic       li_n,
   output logic       ei_n,
   output logic       la_n,
   output logic       ea,
   output logic       su,
   output logic       eu,
   output logic       lb_n,
   output logic       lo_n,
   output logic       hlt,
   output logic [5:0] t_state
);

   typedef enum logic [5:0] {
      T1 = 6'b000001,
      T2 = 6'b000010,
      T3 = 6'b000100,
      T4 = 6'b001000,
      T5 = 6'b010000,
      T6 = 6'b100000
   } t_state_e;

   t_state_e state, state_next;
   logic     halted, halted_next;
   logic     freeze;

   // Once HLT is seen at T4 the halted flag holds the ring there, even if the
   // opcode input later changes, until rst.
   assign freeze = (state == T4) && (halted || opcode == OP_HLT);

   always_comb begin
      state_next  = T1;
      halted_next = freeze;
      case (state)
         T1:      state_next = T2;
         T2:      state_next = T3;
         T3:      state_next = T4;
         T4:      state_next = freeze ? T4 : T5;
         T5:      state_next = T6;
         T6:      state_next = T1;
         default: state_next = T1;  // non-one-hot value recovers to T1
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; the comb block above uses blocking.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= T1;
         halted <= 1'b0;
      end else begin
         state  <= state_next;
         halted <= halted_next;
      end
   end

   assign t_state = state;

   always_comb begin
      // NOTE: every output gets its idle value first so no path infers a latch.
      cp   = 1'b0;
      ep   = 1'b0;
      lm_n = 1'b1;
      ce_n = 1'b1;
      li_n = 1'b1;
      ei_n = 1'b1;
      la_n = 1'b1;
      ea   = 1'b0;
      su   = 1'b0;
      eu   = 1'b0;
      lb_n = 1'b1;
      lo_n = 1'b1;
      hlt  = 1'b0;
      // rst gates the decode so a reset mid-instruction never leaks a partial strobe.
      if (!rst) begin
         if (freeze) begin
            hlt = 1'b1;
         end else begin
            case (state)
               T1: begin
                  ep   = 1'b1;
                  lm_n = 1'b0;
               end
               T2: cp = 1'b1;
               T3: begin
                  ce_n = 1'b0;
                  li_n = 1'b0;
               end
               T4: begin
                  if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
                     ei_n = 1'b0;
                     lm_n = 1'b0;
                  end else if (opcode == OP_OUT) begin
                     ea   = 1'b1;
                     lo_n = 1'b0;
                  end
               end
               T5: begin
                  if (opcode == OP_LDA) begin
                     ce_n = 1'b0;
                     la_n = 1'b0;
                  end else if (opcode == OP_ADD || opcode == OP_SUB) begin
                     ce_n = 1'b0;
                     lb_n = 1'b0;
                  end
               end
               T6: begin
                  if (opcode == OP_ADD || opcode == OP_SUB) begin
                     eu   = 1'b1;
                     la_n = 1'b0;
                     su   = (opcode == OP_SUB);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sap_controller_sequencer.sv
// Scoreboard bench for sap_controller_sequencer: stimulus pushes hand-written
// expected control words per cycle; a negedge monitor pops and compares.
module tb_sap_controller_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] opcode = 4'b0000;
   logic       cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n, hlt;
   logic [5:0] t_state;

   sap_controller_sequencer dut (
      .clk(clk), .rst(rst), .opcode(opcode),
      .cp(cp), .ep(ep), .lm_n(lm_n), .ce_n(ce_n), .li_n(li_n), .ei_n(ei_n),
      .la_n(la_n), .ea(ea), .su(su), .eu(eu), .lb_n(lb_n), .lo_n(lo_n),
      .hlt(hlt), .t_state(t_state)
   );

   always #5 clk = ~clk;

   // Word layout {cp,ep,lm_n,ce_n,li_n,ei_n,la_n,ea,su,eu,lb_n,lo_n,hlt}
   localparam logic [12:0] IDLE = 13'b0011111000110;
   localparam logic [12:0] M_CP = 13'b1000000000000;
   localparam logic [12:0] M_EP = 13'b0100000000000;
   localparam logic [12:0] M_LM = 13'b0010000000000;
   localparam logic [12:0] M_CE = 13'b0001000000000;
   localparam logic [12:0] M_LI = 13'b0000100000000;
   localparam logic [12:0] M_EI = 13'b0000010000000;
   localparam logic [12:0] M_LA = 13'b0000001000000;
   localparam logic [12:0] M_EA = 13'b0000000100000;
   localparam logic [12:0] M_SU = 13'b0000000010000;
   localparam logic [12:0] M_EU = 13'b0000000001000;
   localparam logic [12:0] M_LB = 13'b0000000000100;
   localparam logic [12:0] M_LO = 13'b0000000000010;
   localparam logic [12:0] M_HL = 13'b0000000000001;

   localparam logic [5:0] S1 = 6'b000001, S2 = 6'b000010, S3 = 6'b000100,
                          S4 = 6'b001000, S5 = 6'b010000, S6 = 6'b100000;

   typedef struct {
      logic [12:0] w;
      logic [5:0]  t;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   done    = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Apply one cycle of stimulus and enqueue the outputs expected in that cycle.
   task automatic cyc(input logic r, input logic [3:0] op, input logic [5:0] t, input logic [12:0] strobes);
      exp_t e;
      @(posedge clk);
      #1;
      rst    = r;
      opcode = op;
      e.w = IDLE ^ strobes;
      e.t = t;
      q.push_back(e);
   endtask

   task automatic fetch(input logic [3:0] op);
      cyc(1'b0, op, S1, M_EP | M_LM);
      cyc(1'b0, op, S2, M_CP);
      cyc(1'b0, op, S3, M_CE | M_LI);
   endtask

   task automatic instr(input logic [3:0] op, input logic [12:0] w4, input logic [12:0] w5, input logic [12:0] w6);
      fetch(op);
      cyc(1'b0, op, S4, w4);
      cyc(1'b0, op, S5, w5);
      cyc(1'b0, op, S6, w6);
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         int   drivers;
         e = q.pop_front();
         check("ctrl_word", {19'd0, cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n, hlt},
               {19'd0, e.w});
         check("t_state", {26'd0, t_state}, {26'd0, e.t});
         drivers = int'(ep) + int'(!ce_n) + int'(!ei_n) + int'(ea) + int'(eu);
         check("bus_excl", {31'd0, (drivers <= 1) && !(cp && drivers != 0)}, 32'd1);
      end
   end

   initial begin
      @(posedge clk);
      // 1: reset for two cycles, then T1 fetch
      cyc(1'b1, 4'b0000, S1, '0);
      cyc(1'b1, 4'b0000, S1, '0);
      // 2: LDA
      instr(4'b0000, M_EI | M_LM, M_CE | M_LA, '0);
      // 3: ADD then SUB
      instr(4'b0001, M_EI | M_LM, M_CE | M_LB, M_EU | M_LA);
      instr(4'b0010, M_EI | M_LM, M_CE | M_LB, M_EU | M_LA | M_SU);
      // 5: OUT then undefined opcode
      instr(4'b1110, M_EA | M_LO, '0, '0);
      instr(4'b0101, '0, '0, '0);
      // 4: HLT held 12 cycles from T4, then reset releases it
      fetch(4'b1111);
      for (int i = 0; i < 12; i++) cyc(1'b0, 4'b1111, S4, M_HL);
      cyc(1'b0, 4'b1110, S4, M_HL);
      cyc(1'b1, 4'b1111, S4, '0);
      // 6: ADD with reset in T5
      fetch(4'b0001);
      cyc(1'b0, 4'b0001, S4, M_EI | M_LM);
      cyc(1'b1, 4'b0001, S5, '0);
      cyc(1'b0, 4'b0000, S1, M_EP | M_LM);
      cyc(1'b0, 4'b0000, S2, M_CP);
      @(negedge clk);
      #1;
      check("queue_drained", q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      done = 1'b1;
      $finish;
   end

   initial begin
      #100000;
      if (!done) begin
         $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
         $fatal(1, "watchdog");
      end
   end

endmodule

// File: doc/sap_controller_sequencer.md
Name: sap_controller_sequencer

Overview:
- Microcoded control sequencer for the 8-bit SAP-style datapath. It initiates every transfer on w_bus, including the active-low lb_n load strobe consumed by register B.
- A 6-state one-hot ring counter (T1..T6) runs one instruction per 6 clocks.
- The control word is decoded from the current T-state and the opcode held in the instruction register.

Parameters:
- OP_LDA, 4'b0000, opcode for load accumulator from memory
- OP_ADD, 4'b0001, opcode for A <= A + mem
- OP_SUB, 4'b0010, opcode for A <= A - mem
- OP_OUT, 4'b1110, opcode for output register <= A
- OP_HLT, 4'b1111, opcode for halt

Ports:
- clk  input  1  single system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- opcode  input  4  upper nibble of the instruction register; stable from T4 through T6
- cp  output  1  PC increment enable, active-high
- ep  output  1  PC drive w_bus, active-high
- lm_n  output  1  MAR load, active-low
- ce_n  output  1  RAM drive w_bus, active-low
- li_n  output  1  instruction register load, active-low
- ei_n  output  1  IR operand nibble drive w_bus, active-low
- la_n  output  1  accumulator load, active-low
- ea  output  1  accumulator drive w_bus, active-high
- su  output  1  ALU subtract select, 1 = subtract
- eu  output  1  ALU drive w_bus, active-high
- lb_n  output  1  register B load, active-low
- lo_n  output  1  output register load, active-low
- hlt  output  1  halt indicator, active-high
- t_state  output  6  one-hot ring state; bit0 = T1 … bit5 = T6

Behaviour:

Interface:
- One clock, clk. Reset rst is synchronous and active-high.

Reset:
- While rst=1, every output is idle: cp=ep=ea=su=eu=hlt=0; lm_n=ce_n=li_n=ei_n=la_n=lb_n=lo_n=1.
- t_state loads 6'b000001 at the rising edge where rst=1.
- The first cycle after rst falls is T1.
- rst takes priority over halt and over any T-state.

Ring counter:
- Advances one position per clock: T1 -> T2 -> … -> T6 -> T1.
- Exactly one bit of t_state is set at all times.
- If an illegal state is detected (not one-hot), it loads T1 on the next edge.

Control word:
- Combinational decode of the registered t_state and opcode.
- Every unlisted signal is idle; each strobe lasts exactly one cycle.

Fetch (all opcodes):
- T1: ep=1, lm_n=0
- T2: cp=1
- T3: ce_n=0, li_n=0

Execute:
- LDA, T4: ei_n=0, lm_n=0
- LDA, T5: ce_n=0, la_n=0
- LDA, T6: idle
- ADD/SUB, T4: ei_n=0, lm_n=0
- ADD/SUB, T5: ce_n=0, lb_n=0
- ADD/SUB, T6: eu=1, la_n=0; su=1 for SUB only, su=0 for ADD
- OUT, T4: ea=1, lo_n=0
- OUT, T5–T6: idle
- HLT, T4: hlt=1, and the ring counter freezes at T4.
  - hlt stays 1 and t_state stays 6'b001000 until rst.
  - No other strobe asserts while halted.
- Any other opcode: T4–T6 idle (NOP), then wrap to T1.

Bus ownership:
- At most one driver per cycle: ep, ce_n=0, ei_n=0, ea, eu are mutually exclusive.
- cp never coincides with any bus driver.

Mid-operation reset:
- rst asserted in any T-state forces idle outputs that same cycle (no partial strobe).
- T1 follows on the next cycle.

Test Plan:
1. rst=1 for 2 cycles, then release -> all outputs idle during reset; t_state=000001 on the first post-reset cycle with ep=1, lm_n=0.
2. opcode=0000 (LDA) over 7 cycles -> T1 ep/lm_n; T2 cp; T3 ce_n/li_n; T4 ei_n/lm_n; T5 ce_n/la_n; T6 idle; cycle 7 t_state=000001 again.
3. opcode=0001 (ADD), then 0010 (SUB) -> T5 lb_n=0 with ce_n=0 for exactly one cycle; T6 eu=1, la_n=0, with su=0 for ADD and su=1 for SUB. lb_n=1 in every other cycle.
4. opcode=1111 (HLT), hold 12 cycles -> from T4 on, hlt=1, t_state=001000, cp never pulses. Then rst=1 -> hlt=0 and T1 next cycle.
5. opcode=1110 (OUT), then 0101 (undefined) -> OUT gives ea=1, lo_n=0 at T4 only. The undefined opcode gives idle T4–T6 and wraps to T1.
6. ADD in progress, rst=1 asserted during T5 -> lb_n=1 and ce_n=1 in that cycle; next cycle t_state=000001. Bus-exclusivity check passes every cycle of scenarios 2–6.
